// File: rtl/gray_seq_checker.sv
// gray_seq_checker: receive-side monitor for a reflected-Gray counter stream.
// Decodes each valid Gray sample to binary, locks onto an incrementing
// sequence, flags illegal transitions and counts wrap-arounds.
//
// Optional feature macro: GRAY_REVERSE_EN
//   When defined, LOCKED also accepts decrements, a 0->max step counts as a
//   wrap, and a Dir output reports the direction of the last legal step.
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   synchronous active-high reset
//   In_Valid   in   In_Gray is sampled this cycle
//   In_Gray    in   incoming Gray code [WIDTH]
//   Err_Clr    in   clears sticky Err (not Err_Count)
//   Bin_Out    out  registered binary of the last sampled code [WIDTH]
//   Bin_Valid  out  one-cycle pulse when Bin_Out was updated
//   Locked     out  high while in LOCKED
//   Wrap       out  one-cycle pulse on a legal wrap while LOCKED
//   Wrap_Count out  saturating wrap counter [CNT_W]
//   Err        out  sticky illegal-transition flag
//   Err_Count  out  saturating illegal-transition counter [CNT_W]
//   Dir        out  (GRAY_REVERSE_EN only) 1 = last legal step was a decrement
module gray_seq_checker #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  input  logic [WIDTH-1:0] In_Gray,
  input  logic             Err_Clr,
  output logic [WIDTH-1:0] Bin_Out,
  output logic             Bin_Valid,
  output logic             Locked,
  output logic             Wrap,
  output logic [CNT_W-1:0] Wrap_Count,
  output logic             Err,
  output logic [CNT_W-1:0] Err_Count
`ifdef GRAY_REVERSE_EN
  ,
  output logic             Dir
`endif
);

  typedef enum logic [1:0] {StUnlocked, StLocking, StLocked, StFault} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [3:0]         good_q, good_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic               bin_valid_q, bin_valid_d;
  logic               wrap_q, wrap_d;
  logic [CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]   sample_bin;
  logic [WIDTH-1:0]   expected;
  logic               err_hit;
`ifdef GRAY_REVERSE_EN
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   expected_dn;
`endif

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    sample_bin = '0;
    sample_bin[WIDTH-1] = In_Gray[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      sample_bin[i] = sample_bin[i+1] ^ In_Gray[i];
    end
  end

  assign expected = prev_q + WIDTH'(1);
`ifdef GRAY_REVERSE_EN
  assign expected_dn = prev_q - WIDTH'(1);
`endif

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_d      = good_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    wrap_d      = 1'b0;
    err_hit     = 1'b0;
`ifdef GRAY_REVERSE_EN
    dir_d       = dir_q;
`endif

    if (In_Valid) begin
      bin_d       = sample_bin;
      bin_valid_d = 1'b1;
      prev_d      = sample_bin;
      case (state_q)
        StUnlocked, StFault: begin
          // Resynchronise on whatever arrives; never an error.
          good_d  = '0;
          state_d = StLocking;
        end
        StLocking: begin
          if (sample_bin == expected) begin
            good_d = good_q + 4'd1;
            if ((good_q + 4'd1) == 4'(LOCK_CNT)) begin
              state_d = StLocked;
            end
          end else if (sample_bin != prev_q) begin
            good_d = '0;
          end
        end
        StLocked: begin
          if (sample_bin == expected) begin
            wrap_d = (prev_q == {WIDTH{1'b1}});
`ifdef GRAY_REVERSE_EN
            dir_d  = 1'b0;
`endif
          end else if (sample_bin == prev_q) begin
            // Hold is legal and changes nothing.
`ifdef GRAY_REVERSE_EN
          end else if (sample_bin == expected_dn) begin
            wrap_d = (prev_q == '0);
            dir_d  = 1'b1;
`endif
          end else begin
            err_hit = 1'b1;
            state_d = StFault;
          end
        end
        default: state_d = StUnlocked;
      endcase
    end

    wrap_cnt_d = wrap_cnt_q;
    if (wrap_d && (wrap_cnt_q != {CNT_W{1'b1}})) begin
      wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
    end

    err_cnt_d = err_cnt_q;
    if (err_hit && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    // A new error beats a simultaneous clear.
    err_d = err_q;
    if (err_hit) begin
      err_d = 1'b1;
    end else if (Err_Clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StUnlocked;
      prev_q      <= '0;
      good_q      <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      wrap_cnt_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
`ifdef GRAY_REVERSE_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      wrap_q      <= wrap_d;
      wrap_cnt_q  <= wrap_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
`ifdef GRAY_REVERSE_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign Bin_Out    = bin_q;
  assign Bin_Valid  = bin_valid_q;
  assign Locked     = (state_q == StLocked);
  assign Wrap       = wrap_q;
  assign Wrap_Count = wrap_cnt_q;
  assign Err        = err_q;
  assign Err_Count  = err_cnt_q;
`ifdef GRAY_REVERSE_EN
  assign Dir        = dir_q;
`endif

endmodule

// File: tb/tb_gray_seq_checker.sv
// Testbench for gray_seq_checker: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural model.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_gray_seq_checker;

  localparam int W  = 3;
  localparam int M  = 1 << W;
  localparam int LC = 2;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_gray = '0;
  logic         err_clr = 1'b0;

  logic [W-1:0] bin_out, bin_out2;
  logic         bin_valid, bin_valid2, locked, locked2, wrap, wrap2, err, err2;
  logic [7:0]   wrap_cnt, err_cnt;
  logic [1:0]   wrap_cnt2, err_cnt2;
`ifdef GRAY_REVERSE_EN
  logic         dir, dir2;
`endif

  always #5 Clk = ~Clk;

  gray_seq_checker #(.WIDTH(W), .LOCK_CNT(LC), .CNT_W(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .In_Valid   (in_valid),
    .In_Gray    (in_gray),
    .Err_Clr    (err_clr),
    .Bin_Out    (bin_out),
    .Bin_Valid  (bin_valid),
    .Locked     (locked),
    .Wrap       (wrap),
    .Wrap_Count (wrap_cnt),
    .Err        (err),
    .Err_Count  (err_cnt)
`ifdef GRAY_REVERSE_EN
    ,
    .Dir        (dir)
`endif
  );

  gray_seq_checker #(.WIDTH(W), .LOCK_CNT(LC), .CNT_W(2)) dut_sat (
    .Clk        (Clk),
    .Reset      (Reset),
    .In_Valid   (in_valid),
    .In_Gray    (in_gray),
    .Err_Clr    (err_clr),
    .Bin_Out    (bin_out2),
    .Bin_Valid  (bin_valid2),
    .Locked     (locked2),
    .Wrap       (wrap2),
    .Wrap_Count (wrap_cnt2),
    .Err        (err2),
    .Err_Count  (err_cnt2)
`ifdef GRAY_REVERSE_EN
    ,
    .Dir        (dir2)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model. mode: 0 unlocked, 1 locking, 2 locked, 3 fault.
  int m_mode, m_prev, m_good, m_bin, m_wraps, m_errs;
  bit m_bv, m_wrap, m_err, m_dir;

  function automatic int gray2bin(input int g);
    for (int i = 0; i < M; i++) if ((i ^ (i >> 1)) == g) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] bin2gray(input int b);
    logic [W-1:0] r;
    r = W'(b ^ (b >> 1));
    return r;
  endfunction

  function automatic int sat(input int x, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic model_step(input bit rst, input bit v, input int g, input bit clr);
    int s;
    bit errnow;
    if (rst) begin
      m_mode = 0; m_prev = 0; m_good = 0; m_bin = 0; m_wraps = 0; m_errs = 0;
      m_bv = 0; m_wrap = 0; m_err = 0; m_dir = 0;
      return;
    end
    m_bv = 0;
    m_wrap = 0;
    errnow = 0;
    if (v) begin
      s = gray2bin(g);
      m_bin = s;
      m_bv = 1;
      case (m_mode)
        1: begin
          if (s == (m_prev + 1) % M) begin
            m_good++;
            if (m_good == LC) m_mode = 2;
          end else if (s != m_prev) begin
            m_good = 0;
          end
        end
        2: begin
          if (s == (m_prev + 1) % M) begin
            m_wrap = (m_prev == M - 1);
            m_dir = 0;
          end else if (s == m_prev) begin
            m_wrap = 0;
`ifdef GRAY_REVERSE_EN
          end else if (s == (m_prev + M - 1) % M) begin
            m_wrap = (m_prev == 0);
            m_dir = 1;
`endif
          end else begin
            errnow = 1;
            m_mode = 3;
          end
        end
        default: begin
          m_good = 0;
          m_mode = 1;
        end
      endcase
      m_prev = s;
    end
    if (m_wrap) m_wraps++;
    if (errnow) m_errs++;
    if (errnow) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic check_model();
    chk("bin_out", int'(bin_out), m_bin);
    chk("bin_valid", int'(bin_valid), int'(m_bv));
    chk("locked", int'(locked), int'(m_mode == 2));
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("wrap_count", int'(wrap_cnt), sat(m_wraps, 8));
    chk("err", int'(err), int'(m_err));
    chk("err_count", int'(err_cnt), sat(m_errs, 8));
    chk("sat_wrap", int'(wrap2), int'(m_wrap));
    chk("sat_wrap_count", int'(wrap_cnt2), sat(m_wraps, 2));
    chk("sat_err_count", int'(err_cnt2), sat(m_errs, 2));
`ifdef GRAY_REVERSE_EN
    chk("dir", int'(dir), int'(m_dir));
`endif
  endtask

  task automatic cycle(input bit rst, input bit v, input logic [W-1:0] g, input bit clr);
    Reset = rst;
    in_valid = v;
    in_gray = g;
    err_clr = clr;
    @(posedge Clk);
    model_step(rst, v, int'(g), clr);
    #1;
    check_model();
  endtask

  typedef struct {
    bit           v;
    logic [W-1:0] g;
    bit           clr;
    int           bin;
    bit           bv;
    bit           lk;
    bit           wr;
    int           wc;
    bit           er;
    int           ec;
  } vec_t;

  vec_t tbl[26];
  int   nwrap;
  int   r, b;

  initial begin
    // v, gray, clr | bin, bv, locked, wrap, wrap_count, err, err_count
    tbl[0]  = '{1, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 3'b001, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 3'b011, 0, 2, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 3'b010, 0, 3, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 3'b110, 0, 4, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 3'b111, 0, 5, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 3'b101, 0, 6, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 3'b100, 0, 7, 1, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 3'b000, 0, 0, 1, 1, 1, 1, 0, 0};
    tbl[9]  = '{1, 3'b001, 0, 1, 1, 1, 0, 1, 0, 0};
    tbl[10] = '{1, 3'b011, 0, 2, 1, 1, 0, 1, 0, 0};
    tbl[11] = '{1, 3'b101, 0, 6, 1, 0, 0, 1, 1, 1};
    tbl[12] = '{1, 3'b111, 0, 5, 1, 0, 0, 1, 1, 1};
    tbl[13] = '{1, 3'b101, 0, 6, 1, 0, 0, 1, 1, 1};
    tbl[14] = '{1, 3'b100, 0, 7, 1, 1, 0, 1, 1, 1};
    tbl[15] = '{1, 3'b000, 0, 0, 1, 1, 1, 2, 1, 1};
    tbl[16] = '{1, 3'b001, 0, 1, 1, 1, 0, 2, 1, 1};
    tbl[17] = '{1, 3'b011, 0, 2, 1, 1, 0, 2, 1, 1};
    tbl[18] = '{1, 3'b010, 0, 3, 1, 1, 0, 2, 1, 1};
    tbl[19] = '{0, 3'b111, 0, 3, 0, 1, 0, 2, 1, 1};
    tbl[20] = '{1, 3'b010, 0, 3, 1, 1, 0, 2, 1, 1};
    tbl[21] = '{0, 3'b000, 0, 3, 0, 1, 0, 2, 1, 1};
    tbl[22] = '{1, 3'b010, 0, 3, 1, 1, 0, 2, 1, 1};
    tbl[23] = '{0, 3'b000, 1, 3, 0, 1, 0, 2, 0, 1};
    tbl[24] = '{1, 3'b000, 1, 0, 1, 0, 0, 2, 1, 2};
    tbl[25] = '{0, 3'b000, 1, 0, 0, 0, 0, 2, 0, 2};

    // Reset state
    cycle(1, 0, 3'b000, 0);
    cycle(1, 0, 3'b000, 0);
    chk("reset_bin_out", int'(bin_out), 0);
    chk("reset_locked", int'(locked), 0);

    // Lock/count, illegal jump + relock, hold with gaps, Err_Clr race
    for (int i = 0; i < 26; i++) begin
      cycle(0, tbl[i].v, tbl[i].g, tbl[i].clr);
      chk($sformatf("tbl%0d_bin", i), int'(bin_out), tbl[i].bin);
      chk($sformatf("tbl%0d_bv", i), int'(bin_valid), int'(tbl[i].bv));
      chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].lk));
      chk($sformatf("tbl%0d_wrap", i), int'(wrap), int'(tbl[i].wr));
      chk($sformatf("tbl%0d_wc", i), int'(wrap_cnt), tbl[i].wc);
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].er));
      chk($sformatf("tbl%0d_ec", i), int'(err_cnt), tbl[i].ec);
    end

    // Reset mid-lock at bin 5
    for (int i = 0; i < 6; i++) cycle(0, 1, bin2gray(i), 0);
    chk("pre_reset_locked", int'(locked), 1);
    cycle(1, 0, 3'b000, 0);
    chk("midreset_err", int'(err), 0);
    chk("midreset_err_count", int'(err_cnt), 0);
    chk("midreset_wrap_count", int'(wrap_cnt), 0);
    chk("midreset_locked", int'(locked), 0);
    cycle(0, 1, 3'b000, 0);
    chk("post_reset_first_err", int'(err), 0);
    chk("post_reset_first_locked", int'(locked), 0);
    cycle(0, 1, 3'b001, 0);
    cycle(0, 1, 3'b011, 0);
    chk("post_reset_relock", int'(locked), 1);

    // Saturation: 5 full cycles of the sequence from reset
    cycle(1, 0, 3'b000, 0);
    nwrap = 0;
    for (int i = 0; i <= 5 * M; i++) begin
      cycle(0, 1, bin2gray(i % M), 0);
      if (wrap2) nwrap++;
    end
    chk("sat_wrap_pulses", nwrap, 5);
    chk("sat_wrap_count_final", int'(wrap_cnt2), 3);
    chk("main_wrap_count_final", int'(wrap_cnt), 5);

`ifdef GRAY_REVERSE_EN
    // Reverse: lock at 0 (6,7,0), then 100 (7) and 101 (6)
    cycle(1, 0, 3'b000, 0);
    cycle(0, 1, bin2gray(6), 0);
    cycle(0, 1, bin2gray(7), 0);
    cycle(0, 1, 3'b000, 0);
    chk("rev_locked", int'(locked), 1);
    chk("rev_no_wrap_locking", int'(wrap_cnt), 0);
    cycle(0, 1, 3'b100, 0);
    chk("rev_wrap", int'(wrap), 1);
    chk("rev_dir", int'(dir), 1);
    cycle(0, 1, 3'b101, 0);
    chk("rev_dir2", int'(dir), 1);
    chk("rev_wrap_count", int'(wrap_cnt), 1);
    chk("rev_err", int'(err), 0);
`endif

    // Randomized traffic against the model
    cycle(1, 0, 3'b000, 0);
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(99);
      if (r < 60)      b = (m_prev + 1) % M;
      else if (r < 75) b = m_prev;
      else if (r < 85) b = (m_prev + M - 1) % M;
      else             b = $urandom_range(M - 1);
      cycle(($urandom_range(199) == 0), ($urandom_range(3) != 0), bin2gray(b),
            ($urandom_range(19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
